// File: rtl/bo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bo_pkg
//  Description : Shared definitions for the BO/BC scheduler: FSM state
//                encoding, default parameter values and an index-width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bo_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Default parameter values
    localparam int c_def_nreq    = 4;
    localparam int c_def_w       = 8;
    localparam int c_def_timeout = 64;

    // Width of an index/counter able to hold 0..n-1; never less than 1 bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bo_scheduler_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Scans req starting at
//                index ptr (wrapping modulo NREQ) and returns the first
//                set position.
//  Ports       : req   - request vector
//                ptr   - index with highest priority this round
//                id    - index of the winning request
//                valid - at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import bo_pkg::*;
#(
    parameter  int NREQ = c_def_nreq,
    localparam int c_pw = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [c_pw-1:0] ptr,
    output logic [c_pw-1:0] id,
    output logic            valid
);

    logic [NREQ-1:0] w_rot;
    logic [c_pw-1:0] w_off;
    logic            w_hit;

    // (a + b) mod NREQ for a, b < NREQ; one extra bit absorbs the carry
    function automatic logic [c_pw-1:0] wrap_add(input logic [c_pw-1:0] a,
                                                 input logic [c_pw-1:0] b);
        logic [c_pw:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (c_pw+1)'(NREQ)) begin
            s = s - (c_pw+1)'(NREQ);
        end
        return s[c_pw-1:0];
    endfunction

    // Rotate so that the ptr position lands at bit 0
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_rot[k] = req[wrap_add(ptr, c_pw'(k))];
        end
    end

    // Priority-encode the rotated vector; descending scan leaves the lowest hit
    always_comb begin
        w_off = '0;
        w_hit = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = c_pw'(k);
                w_hit = 1'b1;
            end
        end
    end

    // Un-rotate the offset back to an absolute requester index
    assign id    = wrap_add(ptr, w_off);
    assign valid = w_hit;

endmodule
`default_nettype wire

// File: rtl/bo_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bo_scheduler
//  Description : Round-robin scheduler sharing one BO/BC pair among NREQ
//                requesters. Grants a winner, latches its operand, pulses
//                the control FSM start, waits for completion (with a
//                watchdog) and returns the captured result with a done pulse.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                req, x_in       - requests and packed operands (W per slot)
//                gnt, done       - one-hot owner / one-cycle completion
//                result, err     - captured result / timeout pulse
//                busy            - scheduler not idle
//                inicio, x_bo    - start pulse and operand to the BO/BC
//                h_in, res_bo    - completion flag and result from BO/BC
//  Revision    : 1.0 - initial release
// ============================================================================
module bo_scheduler
    import bo_pkg::*;
#(
    parameter int NREQ    = c_def_nreq,
    parameter int W       = c_def_w,
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] x_in,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [W-1:0]    result,
    output logic            err,
    output logic            busy,
    output logic            inicio,
    output logic [W-1:0]    x_bo,
    input  logic            h_in,
    input  logic [W-1:0]    res_bo
);

    localparam int c_pw = idx_width(NREQ);
    localparam int c_cw = idx_width(TIMEOUT);

    // Registered state
    state_t          r_state;
    logic [c_pw-1:0] r_id;
    logic [c_pw-1:0] r_ptr;
    logic [c_cw-1:0] r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [W-1:0]    r_xbo;
    logic [W-1:0]    r_result;
    logic            r_err;
    logic            r_inicio;
    logic            r_busy;

    // Next-state values
    state_t          w_state;
    logic [c_pw-1:0] w_id;
    logic [c_pw-1:0] w_ptr;
    logic [c_cw-1:0] w_cnt;
    logic [NREQ-1:0] w_gnt;
    logic [W-1:0]    w_xbo;
    logic [W-1:0]    w_result;
    logic            w_err;
    logic            w_inicio;
    logic            w_busy;

    // Arbitration result
    logic [c_pw-1:0] w_pid;
    logic            w_pvalid;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .id    (w_pid),
        .valid (w_pvalid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_id     <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_xbo    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_inicio <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_id     <= w_id;
            r_ptr    <= w_ptr;
            r_cnt    <= w_cnt;
            r_gnt    <= w_gnt;
            r_xbo    <= w_xbo;
            r_result <= w_result;
            r_err    <= w_err;
            r_inicio <= w_inicio;
            r_busy   <= w_busy;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_id     = r_id;
        w_ptr    = r_ptr;
        w_cnt    = r_cnt;
        w_gnt    = r_gnt;
        w_xbo    = r_xbo;
        w_result = r_result;
        w_err    = 1'b0;
        w_inicio = 1'b0;
        w_busy   = r_busy;

        case (r_state)
            S_IDLE: begin
                if (w_pvalid) begin
                    w_id     = w_pid;
                    w_xbo    = x_in[int'(w_pid)*W +: W];
                    w_gnt    = NREQ'(1) << w_pid;
                    w_cnt    = '0;
                    // inicio is registered, so it is raised on the grant
                    // edge to be high exactly while in START
                    w_inicio = 1'b1;
                    w_busy   = 1'b1;
                    w_state  = S_START;
                end
            end

            S_START: begin
                w_state = S_WAIT;
            end

            S_WAIT: begin
                // The first WAIT cycle (count 0) ignores h_in: a flag left
                // over from the previous run may still be asserted. h_in is
                // tested before the watchdog so it wins a tie.
                if ((r_cnt != '0) && h_in) begin
                    w_result = res_bo;
                    w_state  = S_DONE;
                end else if (r_cnt == c_cw'(TIMEOUT - 1)) begin
                    w_result = '0;
                    w_err    = 1'b1;
                    w_state  = S_DONE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_gnt   = '0;
                w_busy  = 1'b0;
                w_ptr   = (r_id == c_pw'(NREQ - 1)) ? '0 : r_id + 1'b1;
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // gnt holds one-hot(id) throughout DONE, so it doubles as the done mask
    assign done   = (r_state == S_DONE) ? r_gnt : '0;
    assign gnt    = r_gnt;
    assign result = r_result;
    assign err    = r_err;
    assign busy   = r_busy;
    assign inicio = r_inicio;
    assign x_bo   = r_xbo;

endmodule
`default_nettype wire

// File: doc/bo_scheduler.md
Name: bo_scheduler

Overview:
Round-robin scheduler that shares one BO/BC pair (operative block plus control FSM) among NREQ requesters. It arbitrates pending requests and latches the winner's operand onto the datapath input. It then pulses the control FSM's start input and waits for the FSM's completion flag. It captures the datapath result, returns it to the winner with a one-cycle done pulse, and enforces a watchdog timeout. It sits between client blocks and the BO/BC pair.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width in bits
TIMEOUT, 64, maximum WAIT cycles before abort (>= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  level request per requester
x_in  input  NREQ*W  operands; requester i uses bits [i*W +: W]
gnt  output  NREQ  one-hot, marks the requester currently owning the datapath
done  output  NREQ  one-cycle pulse to the owner when its result is valid
result  output  W  result register, valid in the done cycle and held until the next capture
err  output  1  one-cycle pulse, concurrent with done, on timeout
busy  output  1  high in any state other than IDLE
inicio  output  1  start pulse to the control FSM
x_bo  output  W  latched operand driven to the datapath
h_in  input  1  completion flag from the control FSM
res_bo  input  W  datapath result bus

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is asynchronous and active-high.
  - All outputs go to 0.
  - State goes to IDLE, round-robin pointer ptr goes to 0, watchdog counter goes to 0.
  - Reset mid-operation aborts with no done or err pulse.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - On that edge: latch id, set x_bo to x_in[id], set gnt to one-hot(id), load the counter with 0, go to START.
  - If req is zero, stay in IDLE.
- START:
  - inicio=1 for exactly one cycle. Go to WAIT.
  - Latency: request sampled at edge 0, inicio high during cycle 1.
- WAIT:
  - The counter increments every cycle.
  - h_in is ignored in the first WAIT cycle, because a stale flag from the previous run may still be high.
  - From the second WAIT cycle, h_in=1 causes: result <= res_bo, go to DONE.
  - If the counter reaches TIMEOUT-1 without an accepted h_in: result <= 0, flag timeout, go to DONE.
  - If h_in and timeout occur in the same cycle, h_in wins (normal completion).
- DONE:
  - done[id]=1 for one cycle. err=1 for that cycle only if timeout was flagged.
  - gnt clears on exit. ptr <= (id+1) mod NREQ. Go to IDLE.
  - No back-to-back grant in this cycle, so the minimum turnaround is 1 idle cycle between operations.
- Requests:
  - req falling while the requester is owner is ignored; the operation completes and done still pulses.
  - x_in changes after the grant edge do not affect x_bo.
  - gnt stays stable from the grant edge through DONE.
- Outputs are registered. The only exception is done, which is a registered one-hot from state and id.
- Width: the counter is clog2(TIMEOUT) bits. ptr and id are clog2(NREQ) bits, minimum 1.

Decomposition:
- Shared package bo_pkg:
  - state encoding localparams S_IDLE=0, S_START=1, S_WAIT=2, S_DONE=3
  - default widths
- Sub-module rr_picker (parameter NREQ): combinational.
  - Inputs: req, ptr.
  - Outputs: id, valid.
  - Implementation: rotate, priority-encode, un-rotate.
- The scheduler holds the FSM, latches and watchdog.

Test Plan:
- Single request: req=0001, x_in[0]=8'h2A; model asserts h_in 5 cycles after inicio with res_bo=8'h55 -> gnt=0001, x_bo=8'h2A, inicio pulses once, done=0001 for 1 cycle, result=8'h55, err=0.
- Fairness: req=1111 held, ptr=0 after reset -> grant order 0,1,2,3,0. Each done pulse occurs in its own DONE cycle.
- Stale flag: h_in held at 1 throughout -> completion on the second WAIT cycle, not the first; done 3 cycles after inicio.
- Timeout: TIMEOUT=64, h_in stuck at 0 -> after 64 WAIT cycles: done[id]=1, err=1, result=8'h00. Next request is then served normally.
- Request withdrawn: req[2] drops 2 cycles after its grant -> operation still completes, done=0100. The next grant goes to the next pending requester at or after index 3.
- Reset mid-WAIT: rst pulsed during WAIT -> gnt, busy, inicio and result are 0 immediately (asynchronous). No done pulse occurs. After release, ptr=0 and arbitration restarts at requester 0.
